// File: rtl/sim_run_controller.sv
// rtl/sim_run_controller.sv - core reset sequencing and run-end detection for the RISC-V benches
// Holds the core in reset, runs it, and latches why the run ended: tohost, pc self-loop or timeout.
module sim_run_controller #(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 11,
  parameter int STALL_LIMIT  = 8,
  parameter int AUTO_START   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  input  logic             tohost_we,
  input  logic [XLEN-1:0]  tohost_data,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             halted,
  output logic             timeout,
  output logic [XLEN-1:0]  exit_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_LIMIT);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 2);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic               r_core_reset;
  logic               r_running;
  logic               r_done;
  logic               r_pass;
  logic               r_fail;
  logic               r_halted;
  logic               r_timeout;
  logic [XLEN-1:0]    r_exit_code;
  logic [CNT_W-1:0]   r_cycle_count;
  logic [HOLD_W-1:0]  r_hold;
  logic [STALL_W-1:0] r_stall;
  logic [XLEN-1:0]    r_pc_prev;

  logic w_enter_hold;
  logic w_pc_same;
  logic w_exit_tohost;
  logic w_halt;
  logic w_timeout;
  logic w_end;

  assign w_enter_hold  = ((r_state == S_IDLE) && ((AUTO_START != 0) || start)) ||
                         ((r_state == S_DONE) && start);
  // The first RUN cycle (count still zero) always counts as a pc change.
  assign w_pc_same     = (pc == r_pc_prev) && (r_cycle_count != '0);
  assign w_exit_tohost = tohost_we && tohost_data[0];
  assign w_halt        = w_pc_same && (r_stall == STALL_LAST);
  assign w_timeout     = (r_cycle_count == CNT_LAST);
  assign w_end         = w_exit_tohost || w_halt || w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_core_reset  <= 1'b1;
      r_running     <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_halted      <= 1'b0;
      r_timeout     <= 1'b0;
      r_exit_code   <= '0;
      r_cycle_count <= '0;
      r_hold        <= '0;
      r_stall       <= '0;
      r_pc_prev     <= '0;
    end else begin
      r_pc_prev <= pc;
      if (w_enter_hold) begin
        r_state       <= S_HOLD;
        r_core_reset  <= 1'b1;
        r_running     <= 1'b0;
        r_done        <= 1'b0;
        r_pass        <= 1'b0;
        r_fail        <= 1'b0;
        r_halted      <= 1'b0;
        r_timeout     <= 1'b0;
        r_exit_code   <= '0;
        r_cycle_count <= '0;
        r_hold        <= '0;
        r_stall       <= '0;
      end else begin
        case (r_state)
          S_HOLD: begin
            if (r_hold == HOLD_LAST) begin
              r_state      <= S_RUN;
              r_core_reset <= 1'b0;
              r_running    <= 1'b1;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          S_RUN: begin
            r_cycle_count <= r_cycle_count + 1'b1;
            r_stall       <= w_pc_same ? r_stall + 1'b1 : '0;
            if (w_exit_tohost) begin
              r_pass      <= (tohost_data == XLEN'(1));
              r_fail      <= (tohost_data != XLEN'(1));
              r_exit_code <= tohost_data >> 1;
            end else if (w_halt) begin
              r_halted <= 1'b1;
            end else if (w_timeout) begin
              r_timeout <= 1'b1;
            end
            if (w_end) begin
              r_state   <= S_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end
          end
          S_IDLE, S_DONE: begin
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign core_reset  = r_core_reset;
  assign running     = r_running;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign halted      = r_halted;
  assign timeout     = r_timeout;
  assign exit_code   = r_exit_code;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_sim_run_controller.sv
// tb/tb_sim_run_controller.sv - table-driven bench for sim_run_controller
// Three instances: defaults, RESET_CYCLES=3, MAX_CYCLES=100; inputs are shared.
module tb_sim_run_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        we;
  logic [31:0] pc;
  logic [31:0] data;

  logic        cr  [3];
  logic        rn  [3];
  logic        dn  [3];
  logic        ps  [3];
  logic        fl  [3];
  logic        hl  [3];
  logic        to  [3];
  logic [31:0] ex  [3];
  logic [31:0] cc  [3];

  int n_tests = 0;
  int n_fail  = 0;

  sim_run_controller u_a (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .tohost_we(we), .tohost_data(data),
    .core_reset(cr[0]), .running(rn[0]), .done(dn[0]), .pass(ps[0]), .fail(fl[0]),
    .halted(hl[0]), .timeout(to[0]), .exit_code(ex[0]), .cycle_count(cc[0])
  );

  sim_run_controller #(.RESET_CYCLES(3)) u_b (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .tohost_we(we), .tohost_data(data),
    .core_reset(cr[1]), .running(rn[1]), .done(dn[1]), .pass(ps[1]), .fail(fl[1]),
    .halted(hl[1]), .timeout(to[1]), .exit_code(ex[1]), .cycle_count(cc[1])
  );

  sim_run_controller #(.MAX_CYCLES(100)) u_c (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .tohost_we(we), .tohost_data(data),
    .core_reset(cr[2]), .running(rn[2]), .done(dn[2]), .pass(ps[2]), .fail(fl[2]),
    .halted(hl[2]), .timeout(to[2]), .exit_code(ex[2]), .cycle_count(cc[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          d;
    int          tcyc;
    logic [31:0] tdata;
    logic [31:0] pc_sat;
    logic        e_pass;
    logic        e_fail;
    logic        e_halt;
    logic        e_to;
    logic [31:0] e_exit;
    logic [31:0] e_cnt;
    int          e_hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    we    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives pc = 4*k (capped at pc_sat) in RUN cycle k and a tohost write in cycle tcyc.
  task automatic run(input int d, input int tcyc, input logic [31:0] tdata,
                     input logic [31:0] pc_sat, output int hold);
    int k;
    int hi;
    k  = 0;
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      if (dn[d]) break;
      if (cr[d]) hi++;
      if (rn[d]) k++;
      pc   = (32'(4 * k) > pc_sat) ? pc_sat : 32'(4 * k);
      we   = rn[d] && (k == tcyc);
      data = tdata;
      @(negedge clk);
    end
    we   = 1'b0;
    hold = hi - 1;
    chk("done_within_bound", {31'b0, dn[d]}, 32'd1);
  endtask

  vec_t vecs[7];
  int   hold;

  initial begin
    vecs[0] = '{0,  0, 32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'd11, 1};
    vecs[1] = '{1,  5, 32'h1,        32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'd5,  3};
    vecs[2] = '{0,  2, 32'h7,        32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3,        32'd2,  1};
    vecs[3] = '{0,  2, 32'h4,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'd11, 1};
    vecs[4] = '{2,  0, 32'h0,        32'h10,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'd11, 1};
    vecs[5] = '{0,  1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1,  1};
    vecs[6] = '{0, 11, 32'h1,        32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'd11, 1};

    reset = 1'b1;
    start = 1'b0;
    we    = 1'b0;
    pc    = '0;
    data  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_core_reset", {31'b0, cr[0]}, 32'd1);
    chk("rst_running",    {31'b0, rn[0]}, 32'd0);
    chk("rst_done",       {31'b0, dn[0]}, 32'd0);
    chk("rst_flags",      {28'b0, ps[0], fl[0], hl[0], to[0]}, 32'd0);
    chk("rst_exit_code",  ex[0], 32'd0);
    chk("rst_cycle_count", cc[0], 32'd0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      run(vecs[v].d, vecs[v].tcyc, vecs[v].tdata, vecs[v].pc_sat, hold);
      chk($sformatf("v%0d_pass", v),    {31'b0, ps[vecs[v].d]}, {31'b0, vecs[v].e_pass});
      chk($sformatf("v%0d_fail", v),    {31'b0, fl[vecs[v].d]}, {31'b0, vecs[v].e_fail});
      chk($sformatf("v%0d_halted", v),  {31'b0, hl[vecs[v].d]}, {31'b0, vecs[v].e_halt});
      chk($sformatf("v%0d_timeout", v), {31'b0, to[vecs[v].d]}, {31'b0, vecs[v].e_to});
      chk($sformatf("v%0d_exit", v),    ex[vecs[v].d], vecs[v].e_exit);
      chk($sformatf("v%0d_count", v),   cc[vecs[v].d], vecs[v].e_cnt);
      chk($sformatf("v%0d_running", v), {31'b0, rn[vecs[v].d]}, 32'd0);
      chk($sformatf("v%0d_core_rst", v), {31'b0, cr[vecs[v].d]}, 32'd0);
      chk($sformatf("v%0d_hold", v),    32'(hold), 32'(vecs[v].e_hold));
    end

    // DONE is sticky and AUTO_START does not restart it.
    repeat (3) @(negedge clk);
    chk("sticky_done",  {31'b0, dn[0]}, 32'd1);
    chk("sticky_pass",  {31'b0, ps[0]}, 32'd1);
    chk("sticky_count", cc[0], 32'd11);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_done",      {31'b0, dn[0]}, 32'd0);
    chk("restart_flags",     {28'b0, ps[0], fl[0], hl[0], to[0]}, 32'd0);
    chk("restart_core_rst",  {31'b0, cr[0]}, 32'd1);
    chk("restart_count",     cc[0], 32'd0);
    pc = 32'h100;
    @(negedge clk);
    chk("restart_running",   {31'b0, rn[0]}, 32'd1);
    chk("restart_core_low",  {31'b0, cr[0]}, 32'd0);

    start = 1'b1;
    pc    = 32'h104;
    @(negedge clk);
    start = 1'b0;
    pc    = 32'h108;
    chk("start_ignored_run", {31'b0, rn[0]}, 32'd1);
    chk("start_ignored_cnt", cc[0], 32'd1);
    @(negedge clk);
    chk("run_count_2",       cc[0], 32'd2);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_core_rst",   {31'b0, cr[0]}, 32'd1);
    chk("midrun_running",    {31'b0, rn[0]}, 32'd0);
    chk("midrun_flags",      {27'b0, dn[0], ps[0], fl[0], hl[0], to[0]}, 32'd0);
    chk("midrun_count",      cc[0], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
- Parametrised run controller for the RISC-V core benches; replaces the fixed one-cycle reset pulse and fixed run time.
- Sequences core reset for a configurable number of cycles, then lets the core run.
- Ends the run on a tohost write (pass/fail with exit code), a PC self-loop (halt) or a cycle-budget timeout, and reports result flags and the run cycle count.
- Sits between the bench clock/reset source and the core top-level.

Parameters:
XLEN, 32, width of pc and tohost_data
CNT_W, 32, width of cycle_count; MAX_CYCLES must be < 2**CNT_W
RESET_CYCLES, 1, cycles core_reset is held after a run starts; must be >= 1
MAX_CYCLES, 11, maximum RUN-state cycles before timeout; must be >= 1
STALL_LIMIT, 8, consecutive RUN cycles with unchanged pc that signal a halt; must be >= 2
AUTO_START, 1, 1 = leave IDLE without a start pulse

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begins (or restarts) a run
pc  input  XLEN  core program counter
tohost_we  input  1  core store to the tohost address
tohost_data  input  XLEN  store data for tohost
core_reset  output  1  reset to the core, active-high, registered
running  output  1  high while in RUN
done  output  1  sticky; run ended
pass  output  1  sticky; tohost == 1
fail  output  1  sticky; tohost odd and != 1
halted  output  1  sticky; pc self-loop detected
timeout  output  1  sticky; cycle budget exhausted
exit_code  output  XLEN  tohost_data >> 1, captured on the ending write
cycle_count  output  CNT_W  RUN cycles elapsed

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset, sampled on the clk rising edge.
- Reset values:
  - state = IDLE, core_reset = 1.
  - running, done, pass, fail, halted, timeout = 0.
  - exit_code = 0, cycle_count = 0.
  - Internal hold and stall counters = 0.
- Reset mid-run: forces IDLE on the next edge. No flag survives.
- States: IDLE, HOLD, RUN, DONE.
- IDLE:
  - core_reset = 1.
  - Go to HOLD when AUTO_START = 1 or start = 1.
- HOLD:
  - core_reset = 1.
  - Entering HOLD clears all sticky flags, exit_code and cycle_count.
  - Stay exactly RESET_CYCLES cycles, then go to RUN.
- RUN:
  - core_reset = 0, running = 1.
  - cycle_count increments once per RUN cycle.
  - Stall counter: if pc equals the previous cycle's pc it increments; otherwise it resets to 0. Compare against the registered pc and treat the first RUN cycle as a change.
  - Exit checks are evaluated each cycle in priority order; the state goes to DONE on the next edge:
    1. tohost_we with tohost_data[0] = 1: pass if tohost_data == 1, else fail. exit_code = tohost_data >> 1.
    2. tohost_we with tohost_data[0] = 0: ignored. The run continues and the write is not an exit.
    3. Stall counter reaches STALL_LIMIT - 1 with pc still unchanged (STALL_LIMIT equal pc samples): halted.
    4. cycle_count == MAX_CYCLES - 1: timeout. RUN therefore lasts at most MAX_CYCLES cycles.
  - start is ignored in RUN.
- DONE:
  - running = 0, done = 1, core_reset = 0.
  - cycle_count is frozen and includes the ending cycle.
  - Flags hold until reset or start.
  - start goes to HOLD (restart). AUTO_START does not restart from DONE.
- Exactly one of pass/fail/halted/timeout is set in DONE.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Defaults, reset high for 1 cycle, pc increments by 4 every cycle, no tohost.
   - core_reset high until 1 cycle after reset falls.
   - RUN lasts 11 cycles, then done = 1, timeout = 1, cycle_count = 11.
2. RESET_CYCLES = 3, tohost_we = 1 with data 0x1 on the 5th RUN cycle.
   - core_reset is high exactly 3 cycles after IDLE.
   - Then pass = 1, exit_code = 0, cycle_count = 5.
3. tohost_data 0x7 on RUN cycle 2 → fail = 1, exit_code = 3, pass = 0.
4. tohost_data 0x4 (even) on RUN cycle 2, then nothing → run continues; timeout = 1 at cycle 11.
5. MAX_CYCLES = 100, STALL_LIMIT = 8, pc increments for 4 cycles, then stays at 0x10 → halted = 1 after 8 equal samples, cycle_count = 11.
6. Simultaneous and restart events:
   - tohost 0x1 and the timeout cycle together → pass, not timeout.
   - Then start pulse → flags clear, HOLD re-entered.
   - reset asserted mid-RUN → IDLE, core_reset = 1, all flags 0 next cycle.
